// File: rtl/mont_convert_if.sv
// Request/response bundle for the Montgomery domain converter.
// The master side drives the operands and start. The slave side returns
// result, busy, done and err.
interface mont_convert_if #(
  parameter int WIDTH = 2048,
  parameter int KW    = 12
);
  // Handshake: start is a level request. It is accepted on a rising clk edge
  // only while busy=0 and the converter is idle. Operands need to be valid
  // only on that accepting edge. done (with err) is a single-cycle strobe
  // marking result valid. There is no backpressure on the response.
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] n;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, mode, x, n, k,
    input  result, busy, done, err
  );

  modport slave (
    input  start, mode, x, n, k,
    output result, busy, done, err
  );
endinterface

// File: rtl/mont_convert.sv
// Converts an operand into the Montgomery domain (x*2^k mod n), or produces
// R^2 mod n (2^(2k) mod n), by repeated modular doubling, one bit per cycle.
module mont_convert #(
  parameter int WIDTH = 2048,
  parameter int KW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  mont_convert_if.slave      bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [KW:0]      cnt_q;
  logic             err_flag_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH:0]   dbl_d;
  logic             ge_d;
  logic [WIDTH-1:0] acc_d;
  logic             start_err_d;
  logic [WIDTH-1:0] start_acc_d;
  logic [KW:0]      start_cnt_d;

  // Because acc < n, the quantity 2*acc - n is always below n. Its upper bit
  // is therefore zero and only the low WIDTH bits of the difference are kept.
  always_comb begin
    dbl_d = {acc_q, 1'b0};
    ge_d  = (dbl_d >= {1'b0, n_q});
    acc_d = dbl_d[WIDTH-1:0];
    if (ge_d) begin
      acc_d = dbl_d[WIDTH-1:0] - n_q;
    end
  end

  always_comb begin
    start_err_d = (bus.n == '0) || (!bus.mode && (bus.x >= bus.n));
    start_cnt_d = bus.mode ? {bus.k, 1'b0} : {1'b0, bus.k};
    start_acc_d = bus.x;
    if (bus.mode) begin
      start_acc_d = (bus.n == WIDTH'(1)) ? '0 : WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            n_q    <= bus.n;
            busy_q <= 1'b1;
            if (start_err_d) begin
              err_flag_q <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= FIN;
            end else begin
              err_flag_q <= 1'b0;
              acc_q      <= start_acc_d;
              cnt_q      <= start_cnt_d;
              state_q    <= (start_cnt_d != '0) ? RUN : FIN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - (KW+1)'(1);
          if (cnt_q == (KW+1)'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          err_q    <= err_flag_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mont_convert.md
MONT_CONVERT -- requirements
Module: mont_convert

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 2048, giving the operand and modulus width in bits (minimum 4).
REQ-002 The block SHALL provide parameter KW, default 12, giving the width of the shift-count input.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL provide port start, input, 1 bit, a request to begin a conversion; sampled only in IDLE.
REQ-006 The block SHALL provide port mode, input, 1 bit: 0 computes x*2^k mod n; 1 computes 2^(2k) mod n, with x ignored.
REQ-007 The block SHALL provide port x, input, WIDTH bits, the operand.
REQ-008 The block SHALL provide port n, input, WIDTH bits, the modulus.
REQ-009 The block SHALL provide port k, input, KW bits, the shift count (R = 2^k).
REQ-010 The block SHALL provide port result, output, WIDTH bits, the conversion result.
REQ-011 The block SHALL provide port busy, output, 1 bit, high while a conversion is in progress.
REQ-012 The block SHALL provide port done, output, 1 bit, a one-cycle pulse marking result valid.
REQ-013 The block SHALL provide port err, output, 1 bit, a one-cycle pulse, coincident with done, flagging illegal operands.

Function
REQ-014 The state machine SHALL have the states IDLE, RUN and FIN.
REQ-015 In IDLE with start=1, the block SHALL capture n, mode and its start values in one edge:
- shift count = k when mode=0, or 2k when mode=1 (counter KW+1 bits wide);
- acc = x when mode=0;
- acc = 1 when mode=1 and n>1, or acc = 0 when mode=1 and n==1.
REQ-016 At capture the block SHALL check the operands: n==0, or mode=0 with x>=n, sets the internal error flag, clears acc and the shift count, and enters FIN directly.
REQ-017 With legal operands, the block SHALL go from IDLE to RUN when the shift count is nonzero, else to FIN.
REQ-018 Each RUN cycle SHALL update acc and the counter:
- t = {acc,1'b0}, WIDTH+1 bits, with no truncation;
- acc <= (t >= n) ? t - n : t;
- the shift count decrements by 1.
REQ-019 The block SHALL hold the invariant acc < n after every update.
REQ-020 RUN SHALL go to FIN on the cycle the shift count reaches 0.
REQ-021 In FIN, result SHALL be registered from acc, done=1 and err=the error flag for exactly one cycle, then the state returns to IDLE.
REQ-022 result SHALL hold its value until the next FIN or reset.
REQ-023 Latency SHALL be exactly s+1 cycles from the start-accepting edge to the edge where done rises, where s is the effective shift count (0 on error).
REQ-024 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 A start held high through FIN SHALL be accepted on the first IDLE cycle after FIN, giving back-to-back conversions separated by one IDLE cycle.
REQ-027 x, n, k and mode SHALL be don't-care after the capture edge; the block SHALL use only registered copies.
REQ-028 The block SHALL perform at most one compare and one subtract of WIDTH+1 bits per cycle, with no multipliers.

Reset
REQ-029 While rst=1, asynchronously, the block SHALL force: state=IDLE, acc=0, shift count=0, error flag=0, result=0, busy=0, done=0, err=0.
REQ-030 Reset asserted mid-RUN SHALL abort the conversion with no done pulse; the first start after rst deasserts SHALL begin a fresh conversion.
REQ-031 start coincident with rst SHALL be ignored.

Verification (WIDTH=8, KW=4)
REQ-032 mode=0, x=5, n=13, k=4, start for one cycle -> done 5 cycles later, result=2, err=0, busy high 5 cycles.
REQ-033 mode=1, n=13, k=4 -> done 9 cycles after start, result=9 (256 mod 13).
REQ-034 mode=0, x=200, n=251, k=0 -> done 1 cycle after start, result=200; then mode=1, n=1, k=3 -> result=0, err=0.
REQ-035 Illegal operands -> done and err in the cycle after start, result=0:
- mode=0, n=0, x=3;
- mode=0, x=13, n=13.
REQ-036 Start x=5, n=13, k=4, assert rst 2 cycles later for 1 cycle -> no done, result=0; a restart with the same operands -> result=2.
REQ-037 Start pulses during busy -> ignored; start held high -> consecutive done pulses 6 cycles apart for k=4, mode=0.
